// File: rtl/hms_time_counter.sv
// Time-of-day counter in packed BCD (00:00:00 .. 23:59:59).
// Advances on each rising edge of the 1 Hz sec_clk (sampled in the clk_in
// domain), with a validated set request/ack path, hold, and rollover strobes.
module hms_time_counter #(
    parameter logic [7:0] RESET_HH = 8'h00,
    parameter logic [7:0] RESET_MM = 8'h00,
    parameter logic [7:0] RESET_SS = 8'h00
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       sec_clk,
    input  logic       hold,
    input  logic       set_valid,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_ack,
    output logic       set_err,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       day_pulse
);

    // BCD +1 for a 00..59 field; wraps 59 -> 00.
    function automatic logic [7:0] inc_sixty(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) return 8'h00;
            return {v[7:4] + 4'd1, 4'h0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD +1 for the hour field; wraps 23 -> 00.
    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        if (v == 8'h23) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Both nibbles decimal and the BCD value no larger than lim (also BCD),
    // so a plain byte compare against lim is a valid range check.
    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    logic       sec_d;
    logic       tick;
    logic       set_ok;
    logic       load;
    logic       advance;
    logic       ss_wrap;
    logic       mm_wrap;
    logic       day_wrap;
    logic [7:0] hh_n;
    logic [7:0] mm_n;
    logic [7:0] ss_n;

    // Decode tick, set validity and the next time value; a valid set wins over a tick.
    always_comb begin
        tick     = sec_clk & ~sec_d;
        set_ok   = bcd_in_range(set_hh, 8'h23) & bcd_in_range(set_mm, 8'h59)
                 & bcd_in_range(set_ss, 8'h59);
        load     = set_valid & set_ok;
        advance  = tick & ~hold & ~load;
        ss_wrap  = (ss == 8'h59);
        mm_wrap  = ss_wrap & (mm == 8'h59);
        day_wrap = mm_wrap & (hh == 8'h23);
        hh_n     = hh;
        mm_n     = mm;
        ss_n     = ss;
        if (load) begin
            hh_n = set_hh;
            mm_n = set_mm;
            ss_n = set_ss;
        end else if (advance) begin
            ss_n = inc_sixty(ss);
            if (ss_wrap) mm_n = inc_sixty(mm);
            if (mm_wrap) hh_n = inc_hour(hh);
        end
    end

    // Register the edge-detect flop, the time and all single-cycle strobes.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sec_d     <= 1'b0;
            hh        <= RESET_HH;
            mm        <= RESET_MM;
            ss        <= RESET_SS;
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
            sec_pulse <= 1'b0;
            min_pulse <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            sec_d     <= sec_clk;
            hh        <= hh_n;
            mm        <= mm_n;
            ss        <= ss_n;
            set_ack   <= load;
            set_err   <= set_valid & ~set_ok;
            sec_pulse <= advance;
            min_pulse <= advance & ss_wrap;
            day_pulse <= advance & day_wrap;
        end
    end

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter: table of set requests, directed corner
// sequences, then random traffic against a seconds-of-day reference model.
module tb_hms_time_counter;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       sec_clk = 1'b0;
    logic       hold = 1'b0;
    logic       set_valid = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
    logic       set_ack, set_err, sec_pulse, min_pulse, day_pulse;
    logic [7:0] hh, mm, ss;

    hms_time_counter dut (
        .clk_in(clk_in), .rst(rst), .sec_clk(sec_clk), .hold(hold),
        .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .set_ack(set_ack), .set_err(set_err), .hh(hh), .mm(mm), .ss(ss),
        .sec_pulse(sec_pulse), .min_pulse(min_pulse), .day_pulse(day_pulse)
    );

    always #5 clk_in = ~clk_in;

    int   errors = 0;
    int   checks = 0;
    int   sp_count = 0;
    // Reference model: time as seconds since midnight plus expected strobes.
    int   m_t = 0;
    logic m_sec_d = 1'b0;
    logic e_ack = 0, e_err = 0, e_sp = 0, e_mp = 0, e_dp = 0;

    typedef struct {
        logic [7:0]  h, m, s;
        logic        ack, err;
        logic [23:0] after_tick;
    } set_vec_t;

    set_vec_t tbl[9];

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int from_bcd(logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit field_ok(logic [7:0] b, int lim);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (from_bcd(b) <= lim);
    endfunction

    function automatic logic [23:0] t_bcd(int t);
        return {to_bcd(t / 3600), to_bcd((t / 60) % 60), to_bcd(t % 60)};
    endfunction

    task automatic check_val(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_all(string name);
        logic [23:0] want_t;
        want_t = t_bcd(m_t);
        checks++;
        if ({hh, mm, ss} !== want_t || set_ack !== e_ack || set_err !== e_err ||
            sec_pulse !== e_sp || min_pulse !== e_mp || day_pulse !== e_dp) begin
            errors++;
            $display("FAIL %s: got %02h:%02h:%02h ack=%b err=%b sp=%b mp=%b dp=%b, want %06h ack=%b err=%b sp=%b mp=%b dp=%b",
                     name, hh, mm, ss, set_ack, set_err, sec_pulse, min_pulse, day_pulse,
                     want_t, e_ack, e_err, e_sp, e_mp, e_dp);
        end
    endtask

    // One clock: advance the model from the inputs seen at the edge, then compare.
    task automatic step(string name);
        bit tick, ok;
        @(posedge clk_in);
        tick    = sec_clk && !m_sec_d;
        m_sec_d = sec_clk;
        ok      = field_ok(set_hh, 23) && field_ok(set_mm, 59) && field_ok(set_ss, 59);
        {e_ack, e_err, e_sp, e_mp, e_dp} = '0;
        if (set_valid && ok) begin
            m_t   = from_bcd(set_hh) * 3600 + from_bcd(set_mm) * 60 + from_bcd(set_ss);
            e_ack = 1;
        end else begin
            e_err = set_valid;
            if (tick && !hold) begin
                e_sp = 1;
                e_mp = (m_t % 60) == 59;
                e_dp = (m_t == 86399);
                m_t  = (m_t + 1) % 86400;
            end
        end
        #1;
        check_all(name);
        if (sec_pulse) sp_count++;
    endtask

    task automatic do_reset(string name);
        rst = 1'b1;
        #1;
        m_t = 0;
        m_sec_d = 1'b0;
        {e_ack, e_err, e_sp, e_mp, e_dp} = '0;
        check_all(name);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
    endtask

    task automatic wave(int edges, int half);
        for (int e = 0; e < edges; e++) begin
            sec_clk = 1'b1;
            for (int i = 0; i < half; i++) step("wave_hi");
            sec_clk = 1'b0;
            for (int i = 0; i < half; i++) step("wave_lo");
        end
    endtask

    task automatic do_set(logic [7:0] h, logic [7:0] m, logic [7:0] s);
        set_hh = h; set_mm = m; set_ss = s; set_valid = 1'b1;
        step("set");
        set_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'h12, 8'h34, 8'h56, 1, 0, 24'h123457};
        tbl[1] = '{8'h24, 8'h00, 8'h00, 0, 1, 24'h123458};
        tbl[2] = '{8'h12, 8'h60, 8'h00, 0, 1, 24'h123459};
        tbl[3] = '{8'h12, 8'h3A, 8'h00, 0, 1, 24'h123500};
        tbl[4] = '{8'h09, 8'h09, 8'h09, 1, 0, 24'h090910};
        tbl[5] = '{8'h19, 8'h59, 8'h59, 1, 0, 24'h200000};
        tbl[6] = '{8'h1A, 8'h00, 8'h00, 0, 1, 24'h200001};
        tbl[7] = '{8'h23, 8'h59, 8'h59, 1, 0, 24'h000000};
        tbl[8] = '{8'h00, 8'h00, 8'h5A, 0, 1, 24'h000001};

        #1;
        do_reset("reset_state");

        // Three rising edges from reset -> 00:00:03, three one-cycle pulses.
        sp_count = 0;
        wave(3, 6);
        check_val("count_3", int'({hh, mm, ss}), 24'h000003);
        check_val("sec_pulses_3", sp_count, 3);

        // Table of set requests, each followed by one tick.
        foreach (tbl[i]) begin
            do_set(tbl[i].h, tbl[i].m, tbl[i].s);
            check_val("tbl_ack", int'(set_ack), int'(tbl[i].ack));
            check_val("tbl_err", int'(set_err), int'(tbl[i].err));
            sec_clk = 1'b1; step("tbl_tick");
            sec_clk = 1'b0; step("tbl_low");
            check_val("tbl_after_tick", int'({hh, mm, ss}), int'(tbl[i].after_tick));
        end

        // Day wrap: all three strobes in the same cycle.
        do_set(8'h23, 8'h59, 8'h58);
        sec_clk = 1'b1; step("to_59");
        sec_clk = 1'b0; step("lo"); step("lo");
        sec_clk = 1'b1; step("day_wrap");
        check_val("wrap_strobes", int'({sec_pulse, min_pulse, day_pulse}), 3'b111);
        check_val("wrap_time", int'({hh, mm, ss}), 24'h000000);
        sec_clk = 1'b0; step("after_wrap");
        check_val("strobes_one_cycle", int'({sec_pulse, min_pulse, day_pulse}), 0);

        // Hold across two edges, released while sec_clk is high.
        do_set(8'h10, 8'h20, 8'h30);
        sp_count = 0;
        hold = 1'b1;
        wave(2, 3);
        sec_clk = 1'b1; step("hold_hi");
        hold = 1'b0;
        step("rel_hi"); step("rel_hi");
        check_val("hold_time", int'({hh, mm, ss}), 24'h102030);
        check_val("hold_no_pulse", sp_count, 0);
        sec_clk = 1'b0; step("lo");
        sec_clk = 1'b1; step("post_hold_tick");
        check_val("post_hold", int'({hh, mm, ss}), 24'h102031);

        // Valid set coincident with a tick: load wins, no pulse.
        sec_clk = 1'b0; step("lo");
        sec_clk = 1'b1;
        do_set(8'h05, 8'h06, 8'h05);
        check_val("set_vs_tick_time", int'({hh, mm, ss}), 24'h050605);
        check_val("set_vs_tick_pulse", int'(sec_pulse), 0);

        // Rejected set coincident with a tick: tick still counts.
        sec_clk = 1'b0; step("lo");
        sec_clk = 1'b1;
        do_set(8'h24, 8'h00, 8'h00);
        check_val("rej_tick_time", int'({hh, mm, ss}), 24'h050606);
        check_val("rej_tick_flags", int'({set_err, set_ack, sec_pulse}), 3'b101);
        sec_clk = 1'b0; step("lo");
        sec_clk = 1'b1; step("to_0507");
        check_val("at_050607", int'({hh, mm, ss}), 24'h050607);

        // Async reset right while sec_pulse is high.
        do_reset("async_reset_mid");
        sec_clk = 1'b0; step("lo");

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) sec_clk = ~sec_clk;
            if ($urandom_range(0, 49) == 0) hold = ~hold;
            set_valid = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0: begin
                    set_hh = 8'($urandom); set_mm = 8'($urandom); set_ss = 8'($urandom);
                end
                1: begin
                    set_hh = 8'h23; set_mm = 8'h59; set_ss = to_bcd($urandom_range(50, 59));
                end
                default: begin
                    set_hh = to_bcd($urandom_range(0, 23));
                    set_mm = to_bcd($urandom_range(0, 59));
                    set_ss = to_bcd($urandom_range(0, 59));
                end
            endcase
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
